// File: rtl/s2p_pkg.sv
// ---------------------------------------------------------------------------
// s2p_pkg
// Shared definitions for the serial_to_parallel receive path:
//   - word_sel codes (which MRAM byte lane(s) a frame targets)
//   - FSM state encoding
//   - frame_len(): number of data bits in a frame for a given sel
// ---------------------------------------------------------------------------
package s2p_pkg;

    localparam logic [1:0] WS_FULL  = 2'b11;
    localparam logic [1:0] WS_LOWER = 2'b01;
    localparam logic [1:0] WS_UPPER = 2'b10;
    localparam logic [1:0] WS_NONE  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } s2p_state_t;

    // Data bits per frame: a whole bus word for WS_FULL, one lane otherwise.
    function automatic int frame_len(input logic [1:0] sel, input int bus_width);
        if (sel == WS_FULL) begin
            return bus_width;
        end
        return bus_width / 2;
    endfunction

endpackage

// File: rtl/s2p_bit_counter.sv
// ---------------------------------------------------------------------------
// s2p_bit_counter
// Loadable bit counter for the serial_to_parallel frame.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en_i       : global enable, counter frozen when low
//   clear_i    : load zero (new frame); wins over inc_i
//   inc_i      : one bit accepted this cycle
//   term_i     : frame length (data bits, plus parity bit when enabled)
//   count_o    : index of the next bit to be accepted
//   tc_o       : terminal count, the next accepted bit completes the frame
// ---------------------------------------------------------------------------
module s2p_bit_counter
    import s2p_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clear_i,
    input  logic          inc_i,
    input  logic [CW-1:0] term_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Terminal when the bit about to be accepted is the last one of the frame.
    assign tc_o    = (count_q == term_i - CW'(1));

endmodule

// File: rtl/serial_to_parallel.sv
// ---------------------------------------------------------------------------
// serial_to_parallel
// Collects an LSB-first serial bitstream into a BUS_WIDTH-bit word, places it
// on the lower lane, upper lane or both lanes per word_sel, and holds it with
// a valid/ack handshake for the MRAM write controller.
//
// Handshake: word_valid rises one clock after the last frame bit and stays
// high, with data_out/byte_en stable, until a cycle with word_ack=1 (and
// en=1); word_valid/byte_en drop on the following edge, data_out keeps its
// last value.
//
// Optional feature macro: PARITY_CHECK_EN -- an even-parity bit follows the
// data bits and the parity_err output is added.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : global enable; everything freezes when low
//   start       : begin a frame, latches word_sel (00 is ignored)
//   word_sel    : 11 full word, 01 lower lane, 10 upper lane
//   bit_valid   : serial_in carries a bit this cycle
//   serial_in   : data bit, LSB first
//   word_ack    : consumer has taken data_out
//   data_out    : assembled word, unused lane reads 0
//   byte_en     : [1] upper lane, [0] lower lane
//   word_valid  : data_out/byte_en valid
//   busy        : high in SHIFT and HOLD
//   overrun     : sticky, bit_valid seen while holding a word
//   parity_err  : (PARITY_CHECK_EN) parity mismatch on the held word
//   state_dbg   : current FSM state
// ---------------------------------------------------------------------------
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [1:0]           word_sel,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    input  logic                 word_ack,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic [1:0]           byte_en,
    output logic                 word_valid,
    output logic                 busy,
    output logic                 overrun,
`ifdef PARITY_CHECK_EN
    output logic                 parity_err,
`endif
    output logic [1:0]           state_dbg
);

    localparam int HALF = BUS_WIDTH / 2;
    localparam int CW   = $clog2(BUS_WIDTH) + 1;
`ifdef PARITY_CHECK_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    s2p_state_t           state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [BUS_WIDTH-1:0] shreg_q, shreg_d, shreg_nx;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [1:0]           be_q, be_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
`ifdef PARITY_CHECK_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    logic                 start_ok;
    logic                 begin_frame;
    logic                 cnt_inc;
    logic                 cnt_tc;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        term;

    // Move the collected bits (always gathered from bit 0 up) onto the target lane.
    function automatic logic [BUS_WIDTH-1:0] place(input logic [1:0] sel,
                                                   input logic [BUS_WIDTH-1:0] w);
        case (sel)
            WS_LOWER: place = {{HALF{1'b0}}, w[HALF-1:0]};
            WS_UPPER: place = {w[HALF-1:0], {HALF{1'b0}}};
            default:  place = w;
        endcase
    endfunction

    assign term = CW'(frame_len(sel_q, BUS_WIDTH)) + CW'(PAR_BITS);

    s2p_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .clear_i (begin_frame),
        .inc_i   (cnt_inc),
        .term_i  (term),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    // Shift register with the current bit written at its index. The parity
    // bit index lies outside the used lane, so it never reaches data_out.
    always_comb begin
        shreg_nx = shreg_q;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (cnt == CW'(i)) begin
                shreg_nx[i] = serial_in;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        be_d        = be_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
`ifdef PARITY_CHECK_EN
        par_d       = par_q;
        perr_d      = perr_q;
`endif
        begin_frame = 1'b0;
        cnt_inc     = 1'b0;
        start_ok    = start && (word_sel != WS_NONE);

        case (state_q)
            IDLE: begin
                begin_frame = start_ok;
            end
            SHIFT: begin
                if (start_ok) begin
                    // Abort and restart; a bit on this cycle is dropped.
                    begin_frame = 1'b1;
                end else if (bit_valid) begin
                    cnt_inc = 1'b1;
                    shreg_d = shreg_nx;
`ifdef PARITY_CHECK_EN
                    par_d   = par_q ^ serial_in;
`endif
                    if (cnt_tc) begin
                        data_d  = place(sel_q, shreg_nx);
                        be_d    = sel_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
`ifdef PARITY_CHECK_EN
                        // Even parity: all data bits plus parity XOR to 0.
                        perr_d  = par_q ^ serial_in;
`endif
                    end
                end
            end
            HOLD: begin
                if (bit_valid) begin
                    ovr_d = 1'b1;
                end
                if (word_ack) begin
                    valid_d     = 1'b0;
                    be_d        = 2'b00;
                    state_d     = IDLE;
                    begin_frame = start_ok;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (begin_frame) begin
            sel_d   = word_sel;
            shreg_d = '0;
            ovr_d   = 1'b0;
            state_d = SHIFT;
`ifdef PARITY_CHECK_EN
            par_d   = 1'b0;
            perr_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= WS_NONE;
            shreg_q <= '0;
            data_q  <= '0;
            be_q    <= 2'b00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else if (en) begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            be_q    <= be_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign byte_en    = be_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = ovr_q;
    assign state_dbg  = state_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// ---------------------------------------------------------------------------
// tb_serial_to_parallel
// Table-driven frames plus hand-written corner sequences. Every completed
// word is predicted into exp_q when its frame is driven and compared when
// word_valid rises.
// ---------------------------------------------------------------------------
module tb_serial_to_parallel;
    import s2p_pkg::*;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         en        = 1'b1;
    logic         start     = 1'b0;
    logic [1:0]   word_sel  = 2'b00;
    logic         bit_valid = 1'b0;
    logic         serial_in = 1'b0;
    logic         word_ack  = 1'b0;
    logic [W-1:0] data_out;
    logic [1:0]   byte_en;
    logic         word_valid;
    logic         busy;
    logic         overrun;
    logic [1:0]   state_dbg;
`ifdef PARITY_CHECK_EN
    logic         parity_err;
`endif

    always #5 clk = ~clk;

    serial_to_parallel #(.BUS_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .word_sel   (word_sel),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .word_ack   (word_ack),
        .data_out   (data_out),
        .byte_en    (byte_en),
        .word_valid (word_valid),
        .busy       (busy),
        .overrun    (overrun),
`ifdef PARITY_CHECK_EN
        .parity_err (parity_err),
`endif
        .state_dbg  (state_dbg)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    logic         prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst && word_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_word: got be=%b data=0x%0h, expected no word", byte_en, data_out);
            end else begin
                check("sb_word", {byte_en, data_out}, exp_q.pop_front());
            end
        end
        prev_valid = word_valid;
    end

    // ---------------- reference helpers ----------------
    function automatic logic [W-1:0] model(input logic [1:0] sel, input logic [W-1:0] p);
        if (sel == 2'b11) return p;
        if (sel == 2'b01) return {8'h00, p[7:0]};
        return {p[7:0], 8'h00};
    endfunction

    function automatic int nbits_of(input logic [1:0] sel);
        return (sel == 2'b11) ? 16 : 8;
    endfunction

    function automatic logic even_par(input logic [W-1:0] p, input int n);
        logic r = 1'b0;
        for (int k = 0; k < n; k++) r ^= p[k];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Start cycle carries a junk bit that must be discarded.
    task automatic do_start(input logic [1:0] sel, input logic junk);
        @(negedge clk);
        start = 1'b1; word_sel = sel; bit_valid = 1'b1; serial_in = junk;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic drive_bits(input logic [W-1:0] p, input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            @(negedge clk);
            start = 1'b0; bit_valid = 1'b1; serial_in = p[k];
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

`ifdef PARITY_CHECK_EN
    task automatic drive_par(input logic b);
        @(negedge clk);
        bit_valid = 1'b1; serial_in = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask
`endif

    // Remaining bits (plus correct parity when built with it), then word_valid
    // must be up one clock after the last bit.
    task automatic finish(input logic [W-1:0] p, input int lo, input int hi);
        drive_bits(p, lo, hi);
`ifdef PARITY_CHECK_EN
        drive_par(even_par(p, hi));
`endif
        check("valid_latency", word_valid, 1'b1);
    endtask

    task automatic send_frame(input logic [1:0] sel, input logic [W-1:0] p);
        do_start(sel, ~p[0]);
        finish(p, 0, nbits_of(sel));
    endtask

    task automatic ack_word();
        @(negedge clk);
        word_ack = 1'b1;
        @(negedge clk);
        word_ack = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] payload;
        logic [W-1:0] exp_data;
        logic [1:0]   exp_be;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b11, 16'hA5C3, 16'hA5C3, 2'b11};
        vecs[1] = '{2'b10, 16'h003C, 16'h3C00, 2'b10};
        vecs[2] = '{2'b01, 16'h007E, 16'h007E, 2'b01};
        vecs[3] = '{2'b11, 16'hFFFF, 16'hFFFF, 2'b11};
        vecs[4] = '{2'b01, 16'h0081, 16'h0081, 2'b01};
        vecs[5] = '{2'b10, 16'h00FF, 16'hFF00, 2'b10};
        for (int i = 6; i < 10; i++) begin
            vecs[i].sel      = 2'($urandom_range(1, 3));
            vecs[i].payload  = 16'($urandom);
            vecs[i].exp_data = model(vecs[i].sel, vecs[i].payload);
            vecs[i].exp_be   = vecs[i].sel;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", data_out, 16'h0000);
        check("rst_be", byte_en, 2'b00);
        check("rst_valid", word_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;

        // Reset mid-frame while an old word sits on data_out
        exp_q.push_back({2'b11, 16'hA5C3});
        send_frame(2'b11, 16'hA5C3);
        ack_word();
        check("ack_keeps_data", data_out, 16'hA5C3);
        do_start(2'b11, 1'b0);
        drive_bits(16'h001F, 0, 5);
        check("midframe_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", data_out, 16'h0000);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_state", state_dbg, IDLE);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].exp_be, vecs[i].exp_data});
            send_frame(vecs[i].sel, vecs[i].payload);
            check("hold_busy", busy, 1'b1);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check("hold_valid", word_valid, 1'b1);
            check("hold_data", data_out, vecs[i].exp_data);
            check("hold_be", byte_en, vecs[i].exp_be);
            ack_word();
            check("ack_valid", word_valid, 1'b0);
            check("ack_be", byte_en, 2'b00);
            check("ack_data_kept", data_out, vecs[i].exp_data);
            check("ack_state", state_dbg, IDLE);
        end

        // Overrun, ignored start in HOLD, start+ack back-to-back
        exp_q.push_back({2'b11, 16'h1234});
        send_frame(2'b11, 16'h1234);
        @(negedge clk); bit_valid = 1'b1; serial_in = 1'b1;
        @(negedge clk); serial_in = 1'b0;
        @(negedge clk); bit_valid = 1'b0;
        check("overrun_set", overrun, 1'b1);
        check("overrun_data", data_out, 16'h1234);
        check("overrun_valid", word_valid, 1'b1);
        @(negedge clk); start = 1'b1; word_sel = 2'b01;
        @(negedge clk); start = 1'b0;
        check("hold_start_ignored", state_dbg, HOLD);
        check("overrun_sticky", overrun, 1'b1);
        @(negedge clk); start = 1'b1; word_sel = 2'b11; word_ack = 1'b1;
        @(negedge clk); start = 1'b0; word_ack = 1'b0;
        check("b2b_overrun_clr", overrun, 1'b0);
        check("b2b_busy", busy, 1'b1);
        check("b2b_valid", word_valid, 1'b0);
        check("b2b_state", state_dbg, SHIFT);
        exp_q.push_back({2'b11, 16'h0001});
        finish(16'h0001, 0, 16);
        ack_word();

        // Illegal sel
        do_start(2'b00, 1'b1);
        check("illegal_state", state_dbg, IDLE);
        check("illegal_busy", busy, 1'b0);

        // Abort full frame after 7 bits, restart as lower lane
        exp_q.push_back({2'b01, 16'h00FF});
        do_start(2'b11, 1'b0);
        drive_bits(16'h007F, 0, 7);
        @(negedge clk); start = 1'b1; word_sel = 2'b01; bit_valid = 1'b1; serial_in = 1'b0;
        @(negedge clk); start = 1'b0; bit_valid = 1'b0;
        finish(16'h00FF, 0, 8);
        check("abort_data", data_out, 16'h00FF);
        check("abort_be", byte_en, 2'b01);
        ack_word();

        // en=0 mid-frame: toggling bits and a start are ignored
        exp_q.push_back({2'b11, 16'h0F0F});
        do_start(2'b11, 1'b0);
        drive_bits(16'h0F0F, 0, 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            en = 1'b0; bit_valid = (c != 1); serial_in = 1'b1;
            start = (c == 1); word_sel = 2'b01;
        end
        @(negedge clk);
        en = 1'b1; start = 1'b0; bit_valid = 1'b0; word_sel = 2'b11;
        check("en_freeze_state", state_dbg, SHIFT);
        finish(16'h0F0F, 4, 16);
        @(negedge clk); en = 1'b0; word_ack = 1'b1;
        @(negedge clk); en = 1'b1; word_ack = 1'b0;
        check("en_low_ack_ignored", word_valid, 1'b1);
        ack_word();
        check("en_ack_valid", word_valid, 1'b0);

`ifdef PARITY_CHECK_EN
        exp_q.push_back({2'b11, 16'h0003});
        do_start(2'b11, 1'b0);
        drive_bits(16'h0003, 0, 16);
        drive_par(1'b0);
        check("par_ok_valid", word_valid, 1'b1);
        check("par_ok_err", parity_err, 1'b0);
        ack_word();
        exp_q.push_back({2'b11, 16'h0001});
        do_start(2'b11, 1'b0);
        drive_bits(16'h0001, 0, 16);
        drive_par(1'b0);
        check("par_bad_valid", word_valid, 1'b1);
        check("par_bad_err", parity_err, 1'b1);
        ack_word();
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
